sad_min_finder: RTL and testbench
=================================

// Module: sad_min_finder
// PURPOSE
//  Writeback-side SAD search unit, fed by the MEM/WB pipeline register.
//  On a find request, snapshots N SAD results and scans them sequentially, one per cycle, to find the minimum or maximum value and its index.
//  Holds a persistent best-SAD register (min_reg) that write_min commits to and read_min writes back to the register file.
//  Asserts stall to freeze the pipeline while a scan is in progress.
// PARAMETERS
//  N_SAD   8   number of SAD operands per search (>=2)
//  W       32  SAD operand / result width (unsigned)
//  IDX_W   3   index width, $clog2(N_SAD)
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        asynchronous, active-low reset
//  find_in       in   1        small_big_find from MEM/WB: start a search (level, sampled in IDLE)
//  big_mode_in   in   1        small_big_regFile from MEM/WB: 0=find min, 1=find max
//  sad_bus_in    in   N_SAD*W  SAD results, operand k at [k*W +: W]
//  write_min_in  in   1        commit result_val to min_reg
//  read_min_in   in   1        write min_reg back to register file
//  rd_addr_in    in   5        destination register for read_min
//  result_val    out  W        value found by last completed search
//  result_idx    out  IDX_W    index of result_val (0..N_SAD-1)
//  min_reg_out   out  W        current min_reg contents
//  busy          out  1        search in progress (SCAN or DONE)
//  done          out  1        one-cycle pulse when result_* update
//  stall         out  1        = busy; pipeline must hold MEM/WB
//  wb_we         out  1        register-file write enable (read_min path)
//  wb_addr       out  5        register-file write address
//  wb_data       out  W        register-file write data
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; result_val, result_idx, busy, done, stall, wb_* =0; min_reg=all-ones; scan buffer/counter=0.
//  FSM IDLE -> SCAN -> DONE -> IDLE.
//   IDLE: find_in=1 -> copy sad_bus_in into internal buffer, latch big_mode_in, best=buf[0], best_idx=0, cnt=1, goto SCAN.
//   SCAN: each cycle compare buf[cnt] with best (unsigned).
//    min mode: replace if buf[cnt] < best. max mode: replace if buf[cnt] > best.
//    Strict comparisons, so ties keep the lowest index.
//    cnt increments. After cnt==N_SAD-1 is compared, goto DONE.
//   DONE: result_val/result_idx <= best/best_idx; done=1 for this cycle only; goto IDLE.
//  Latency: find_in sampled at edge 0 -> done high in cycle N_SAD (8 by default) -> back in IDLE at N_SAD+1.
//  busy=stall=1 from the cycle after the start edge through DONE. Inputs changing during SCAN have no effect (snapshot).
//  find_in while busy: ignored; the upstream stage is held by stall, so the request is re-presented.
//  find_in held high in IDLE after DONE: starts a new search, since it is level sensitive.
//  write_min_in (any state except DONE): min_reg <= result_val at next edge.
//   In DONE: min_reg <= new best, so a commit coincident with done takes the fresh value.
//  read_min_in: registered, 1-cycle latency. Next cycle: wb_we=1, wb_addr=rd_addr_in, wb_data=min_reg value *before* that edge.
//   With no read_min_in: wb_we=0, addr/data hold.
//  read_min_in and write_min_in together: wb_data returns the old min_reg; min_reg takes the new value.
//  find_in and write_min_in together in IDLE: commit uses the previous result_val; the search starts normally.
//  Reset mid-scan: search aborts; all outputs return to reset values; no done pulse.
//  No arithmetic overflow possible (compare/select only); widths are exact W.
// TESTING
//  1. Reset release, idle: min_reg_out=FFFFFFFF, busy=0, wb_we=0; read_min, rd_addr=5 -> next cycle wb_we=1, wb_addr=5, wb_data=FFFFFFFF.
//  2. Min search, sad={40,12,99,12,7,7,300,15} (idx0..7), big_mode=0 -> done exactly 8 cycles after start; result_val=7, result_idx=4; stall high for 8 cycles.
//  3. Max search on the same data with big_mode=1 -> result_val=300, result_idx=6. Then change sad_bus mid-scan to all 0 -> result unchanged.
//  4. write_min asserted in the DONE cycle of test 2 -> min_reg_out=7. Same-cycle read_min+write_min (result 300) -> wb_data=7, then min_reg_out=300.
//  5. find_in pulsed again at SCAN cycle 3 -> ignored; exactly one done pulse. Hold find_in high -> back-to-back searches, done every 9 cycles.
//  6. rst low at SCAN cycle 4 -> immediately busy=0, result_val=0, min_reg=FFFFFFFF; no done after rst is released.

Source files
------------

// File: rtl/sad_min_finder.sv
// Sequential min/max search over N_SAD snapshotted SAD results, one compare per cycle,
// with a persistent best-SAD register that can be written back to the register file.
module sad_min_finder #(
  parameter int N_SAD = 8,
  parameter int W     = 32,
  parameter int IDX_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               find_in,
  input  logic               big_mode_in,
  input  logic [N_SAD*W-1:0] sad_bus_in,
  input  logic               write_min_in,
  input  logic               read_min_in,
  input  logic [4:0]         rd_addr_in,
  output logic [W-1:0]       result_val,
  output logic [IDX_W-1:0]   result_idx,
  output logic [W-1:0]       min_reg_out,
  output logic               busy,
  output logic               done,
  output logic               stall,
  output logic               wb_we,
  output logic [4:0]         wb_addr,
  output logic [W-1:0]       wb_data
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SAD - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       sbuf_q [N_SAD];
  logic [IDX_W-1:0]   cnt_q;
  logic               big_q;
  logic [W-1:0]       best_q;
  logic [IDX_W-1:0]   best_idx_q;
  logic [W-1:0]       res_val_q;
  logic [IDX_W-1:0]   res_idx_q;
  logic               done_q;
  logic [W-1:0]       min_reg_q;
  logic               wb_we_q;
  logic [4:0]         wb_addr_q;
  logic [W-1:0]       wb_data_q;

  logic [W-1:0]       cand;
  logic               take;
  logic [W-1:0]       best_d;
  logic [IDX_W-1:0]   best_idx_d;

  // Strict compare so ties keep the earlier (lower) index.
  always_comb begin
    cand       = sbuf_q[cnt_q];
    take       = big_q ? (cand > best_q) : (cand < best_q);
    best_d     = take ? cand : best_q;
    best_idx_d = take ? cnt_q : best_idx_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (find_in) state_d = SCAN;
      SCAN:    if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N_SAD; k++) sbuf_q[k] <= '0;
      cnt_q      <= '0;
      big_q      <= 1'b0;
      best_q     <= '0;
      best_idx_q <= '0;
      res_val_q  <= '0;
      res_idx_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (find_in) begin
          for (int k = 0; k < N_SAD; k++) sbuf_q[k] <= sad_bus_in[k*W +: W];
          big_q      <= big_mode_in;
          best_q     <= sad_bus_in[W-1:0];
          best_idx_q <= '0;
          cnt_q      <= IDX_W'(1);
        end
        SCAN: begin
          best_q     <= best_d;
          best_idx_q <= best_idx_d;
          cnt_q      <= cnt_q + 1'b1;
          // Publish together with the done pulse so result_* is valid while done is high.
          if (cnt_q == LAST) begin
            res_val_q <= best_d;
            res_idx_q <= best_idx_d;
            done_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Best-SAD register and its register-file writeback path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_reg_q <= '1;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      if (write_min_in) min_reg_q <= (state_q == DONE) ? best_q : res_val_q;
      wb_we_q <= read_min_in;
      if (read_min_in) begin
        wb_addr_q <= rd_addr_in;
        wb_data_q <= min_reg_q;
      end
    end
  end

  assign result_val  = res_val_q;
  assign result_idx  = res_idx_q;
  assign min_reg_out = min_reg_q;
  assign busy        = (state_q != IDLE);
  assign stall       = busy;
  assign done        = done_q;
  assign wb_we       = wb_we_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_sad_min_finder.sv
// Bench for sad_min_finder: directed search scenarios checked against a search-level model
// every cycle, plus hand-computed literal expectations.
module tb_sad_min_finder;
  localparam int N = 8;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           find_in = 1'b0, big_mode_in = 1'b0;
  logic [N*W-1:0] sad_bus_in = '0;
  logic           write_min_in = 1'b0, read_min_in = 1'b0;
  logic [4:0]     rd_addr_in = '0;
  logic [W-1:0]   result_val, min_reg_out, wb_data;
  logic [2:0]     result_idx;
  logic           busy, done, stall, wb_we;
  logic [4:0]     wb_addr;

  sad_min_finder #(.N_SAD(N), .W(W), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .find_in(find_in), .big_mode_in(big_mode_in),
    .sad_bus_in(sad_bus_in), .write_min_in(write_min_in), .read_min_in(read_min_in),
    .rd_addr_in(rd_addr_in), .result_val(result_val), .result_idx(result_idx),
    .min_reg_out(min_reg_out), .busy(busy), .done(done), .stall(stall),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int cyc_no = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
  endtask

  // Search-level model: a search is a snapshot + a plain loop; the unit is then busy
  // for N cycles, with the result appearing on the last of them.
  int           m_age;
  logic [W-1:0] m_best, m_res_val, m_min, m_wb_data;
  int           m_best_idx, m_res_idx;
  logic         m_wb_we;
  logic [4:0]   m_wb_addr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_age = 0; m_best = '0; m_best_idx = 0; m_res_val = '0; m_res_idx = 0;
      m_min = '1; m_wb_we = 1'b0; m_wb_addr = '0; m_wb_data = '0;
    end else begin
      cyc_no++;
      m_wb_we = read_min_in;
      if (read_min_in) begin m_wb_addr = rd_addr_in; m_wb_data = m_min; end
      if (write_min_in) m_min = (m_age == N) ? m_best : m_res_val;
      if (m_age == 0) begin
        if (find_in) begin
          m_best = sad_bus_in[W-1:0]; m_best_idx = 0;
          for (int i = 1; i < N; i++) begin
            logic [W-1:0] v;
            v = sad_bus_in[i*W +: W];
            if (big_mode_in ? (v > m_best) : (v < m_best)) begin m_best = v; m_best_idx = i; end
          end
          m_age = 1;
        end
      end else if (m_age == N) m_age = 0;
      else begin
        m_age++;
        if (m_age == N) begin m_res_val = m_best; m_res_idx = m_best_idx; end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("busy", busy, m_age != 0);
      chk("stall", stall, m_age != 0);
      chk("done", done, m_age == N);
      chk("result_val", result_val, m_res_val);
      chk("result_idx", result_idx, m_res_idx);
      chk("min_reg", min_reg_out, m_min);
      chk("wb_we", wb_we, m_wb_we);
      if (m_wb_we) begin
        chk("wb_addr", wb_addr, m_wb_addr);
        chk("wb_data", wb_data, m_wb_data);
      end
    end
  end

  logic [W-1:0] vals [N] = '{40, 12, 99, 12, 7, 7, 300, 15};

  function automatic logic [N*W-1:0] pack_vals();
    logic [N*W-1:0] b;
    for (int i = 0; i < N; i++) b[i*W +: W] = vals[i];
    return b;
  endfunction

  task automatic cyc(); @(negedge clk); endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40 && busy; k++) cyc();
    chk("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    int ndone, t0, t1;
    // Reset state
    repeat (2) cyc();
    chk("rst_min_reg", min_reg_out, 32'hFFFF_FFFF);
    chk("rst_busy", busy, 0);
    chk("rst_wb_we", wb_we, 0);
    rst = 1'b1;
    cyc();

    // 1: read_min writeback of the reset value
    read_min_in = 1'b1; rd_addr_in = 5'd5;
    cyc();
    read_min_in = 1'b0;
    chk("t1_wb_we", wb_we, 1);
    chk("t1_wb_addr", wb_addr, 5);
    chk("t1_wb_data", wb_data, 32'hFFFF_FFFF);
    cyc();
    chk("t1_wb_we_drop", wb_we, 0);

    // 2 + 4a: min search, commit in the done cycle
    sad_bus_in = pack_vals(); big_mode_in = 1'b0; find_in = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      find_in = 1'b0;
      write_min_in = 1'b0;
      chk("t2_done_cycle", done, k == 8);
      chk("t2_stall", stall, k <= 8);
      if (k == 8) begin
        chk("t2_val", result_val, 7);
        chk("t2_idx", result_idx, 4);
        write_min_in = 1'b1;
      end
      if (k == 9) chk("t4_min_reg", min_reg_out, 7);
    end

    // 3: max search, bus zeroed mid-scan
    big_mode_in = 1'b1; find_in = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      find_in = 1'b0;
      if (k == 2) sad_bus_in = '0;
      if (k == 8) begin
        chk("t3_done", done, 1);
        chk("t3_val", result_val, 300);
        chk("t3_idx", result_idx, 6);
      end
    end

    // 4b: same-cycle read and write of min_reg
    read_min_in = 1'b1; write_min_in = 1'b1; rd_addr_in = 5'd9;
    cyc();
    read_min_in = 1'b0; write_min_in = 1'b0;
    chk("t4_wb_data_old", wb_data, 7);
    chk("t4_min_reg_new", min_reg_out, 300);

    // 5a: find re-pulsed during SCAN is ignored
    sad_bus_in = pack_vals(); big_mode_in = 1'b0; find_in = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      find_in = (k == 3);
      if (done) ndone++;
    end
    chk("t5_one_done", ndone, 1);

    // 5b: find held high gives back-to-back searches
    find_in = 1'b1; t0 = -1; t1 = -1;
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (done) begin
        if (t0 < 0) t0 = cyc_no; else if (t1 < 0) t1 = cyc_no;
      end
    end
    find_in = 1'b0;
    chk("t5_period", t1 - t0, 9);
    wait_idle();
    cyc();

    // 6: reset mid-scan
    big_mode_in = 1'b1; find_in = 1'b1;
    cyc(); find_in = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_val", result_val, 0);
    chk("t6_min_reg", min_reg_out, 32'hFFFF_FFFF);
    chk("t6_done", done, 0);
    cyc();
    rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (done) ndone++;
    end
    chk("t6_no_done", ndone, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
